// File: rtl/ascon_pkg.sv
// Shared Ascon types and constants for the AEAD ingress/egress buffers.
package ascon_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } ascon_ibuf_state_t;

    localparam logic [7:0] ASCON_PAD_BYTE  = 8'h01;
    localparam int         ASCON_RATE_BITS = 128;

endpackage

// File: rtl/ascon_pad_insert.sv
// Masks message bytes at or above the total byte count and inserts the Ascon 0x01 pad byte.
module ascon_pad_insert
    import ascon_pkg::*;
#(
    parameter int BLOCK_WIDTH = ASCON_RATE_BITS
) (
    input  logic [BLOCK_WIDTH-1:0]               raw_block,
    input  logic [$clog2(BLOCK_WIDTH/8+1)-1:0]   total_bytes,
    output logic [BLOCK_WIDTH-1:0]               padded_block
);

    localparam int NUM_BYTES = BLOCK_WIDTH / 8;

    // A full block (total == NUM_BYTES) carries no pad; the caller emits it separately.
    always_comb begin
        padded_block = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (i < int'(total_bytes)) begin
                padded_block[i*8 +: 8] = raw_block[i*8 +: 8];
            end else if (i == int'(total_bytes)) begin
                padded_block[i*8 +: 8] = ASCON_PAD_BYTE;
            end
        end
    end

endmodule

// File: rtl/ascon_input_buffer.sv
// Gathers bus words into one rate block, pads the final partial block, and offers it to the core.
// Handshake: a block transfers on any posedge where block_valid_o & block_ready_i; writes transfer where wr_en_i & wr_ready_o.
module ascon_input_buffer
    import ascon_pkg::*;
#(
    parameter int WORD_WIDTH  = 32,
    parameter int BLOCK_WIDTH = ASCON_RATE_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_i,
    input  logic                                 wr_en_i,
    input  logic [WORD_WIDTH-1:0]                wr_data_i,
    input  logic                                 wr_last_i,
    input  logic [$clog2(WORD_WIDTH/8+1)-1:0]    wr_bytes_i,
    output logic                                 wr_ready_o,
    output logic                                 drop_pulse_o,
    output logic [BLOCK_WIDTH-1:0]               block_o,
    output logic [$clog2(BLOCK_WIDTH/8+1)-1:0]   block_bytes_o,
    output logic                                 block_last_o,
    output logic                                 block_valid_o,
    input  logic                                 block_ready_i
);

    localparam int NUM_WORDS = BLOCK_WIDTH / WORD_WIDTH;
    localparam int NUM_BYTES = BLOCK_WIDTH / 8;
    localparam int CNT_W     = $clog2(NUM_WORDS);
    localparam int BYTES_W   = $clog2(NUM_BYTES + 1);
    localparam int WB_W      = $clog2(WORD_WIDTH/8 + 1);

    localparam logic [WB_W-1:0]    WORD_BYTES = WB_W'(WORD_WIDTH/8);
    localparam logic [CNT_W-1:0]   LAST_WORD  = CNT_W'(NUM_WORDS-1);
    localparam logic [BYTES_W-1:0] FULL_BYTES = BYTES_W'(NUM_BYTES);

    ascon_ibuf_state_t  state;
    logic [CNT_W-1:0]   cnt;
    logic               pad_pending;

    logic [WB_W-1:0]        bytes_sat;
    logic [BYTES_W-1:0]     total_bytes;
    logic [BLOCK_WIDTH-1:0] raw_block;
    logic [BLOCK_WIDTH-1:0] padded_block;

    assign wr_ready_o    = (state == FILL);
    assign block_valid_o = (state == HOLD);

    always_comb begin
        bytes_sat   = (wr_bytes_i > WORD_BYTES) ? WORD_BYTES : wr_bytes_i;
        total_bytes = block_bytes_o + BYTES_W'(bytes_sat);
        raw_block   = block_o;
        for (int w = 0; w < NUM_WORDS; w++) begin
            if (cnt == CNT_W'(w)) begin
                raw_block[w*WORD_WIDTH +: WORD_WIDTH] = wr_data_i;
            end
        end
    end

    ascon_pad_insert #(
        .BLOCK_WIDTH (BLOCK_WIDTH)
    ) u_pad_insert (
        .raw_block    (raw_block),
        .total_bytes  (total_bytes),
        .padded_block (padded_block)
    );

    always_ff @(posedge clk) begin
        drop_pulse_o <= 1'b0;
        if (rst || clear_i) begin
            state         <= FILL;
            cnt           <= '0;
            pad_pending   <= 1'b0;
            block_o       <= '0;
            block_bytes_o <= '0;
            block_last_o  <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_en_i && !wr_last_i) begin
                        block_o       <= raw_block;
                        block_bytes_o <= block_bytes_o + BYTES_W'(WORD_BYTES);
                        if (cnt == LAST_WORD) begin
                            state        <= HOLD;
                            block_last_o <= 1'b0;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (wr_en_i) begin
                        block_o       <= padded_block;
                        block_bytes_o <= total_bytes;
                        block_last_o  <= (total_bytes != FULL_BYTES);
                        pad_pending   <= (total_bytes == FULL_BYTES);
                        cnt           <= '0;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (wr_en_i) begin
                        drop_pulse_o <= 1'b1;
                    end
                    if (block_ready_i) begin
                        // A message ending exactly on a block boundary needs a pad-only block.
                        if (pad_pending) begin
                            block_o       <= BLOCK_WIDTH'(ASCON_PAD_BYTE);
                            block_bytes_o <= '0;
                            block_last_o  <= 1'b1;
                            pad_pending   <= 1'b0;
                        end else begin
                            state         <= FILL;
                            cnt           <= '0;
                            block_o       <= '0;
                            block_bytes_o <= '0;
                            block_last_o  <= 1'b0;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_input_buffer.sv
// Scoreboard bench for ascon_input_buffer: byte-queue message model, directed cases, random messages.
module tb_ascon_input_buffer;

    logic         clk;
    logic         rst;
    logic         clear_i;
    logic         wr_en_i;
    logic [31:0]  wr_data_i;
    logic         wr_last_i;
    logic [2:0]   wr_bytes_i;
    logic         wr_ready_o;
    logic         drop_pulse_o;
    logic [127:0] block_o;
    logic [4:0]   block_bytes_o;
    logic         block_last_o;
    logic         block_valid_o;
    logic         block_ready_i;

    int total = 0;
    int bad   = 0;
    logic rand_ready = 1'b0;

    // Expected entry: {last, bytes[4:0], block[127:0]}
    logic [133:0] exp_q[$];
    logic [7:0]   cur[$];

    ascon_input_buffer #(
        .WORD_WIDTH  (32),
        .BLOCK_WIDTH (128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear_i       (clear_i),
        .wr_en_i       (wr_en_i),
        .wr_data_i     (wr_data_i),
        .wr_last_i     (wr_last_i),
        .wr_bytes_i    (wr_bytes_i),
        .wr_ready_o    (wr_ready_o),
        .drop_pulse_o  (drop_pulse_o),
        .block_o       (block_o),
        .block_bytes_o (block_bytes_o),
        .block_last_o  (block_last_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) block_ready_i = 1'($urandom_range(0, 1));
    endtask

    // Model: message bytes accumulate; a block is emitted at 16 bytes or at message end.
    function automatic logic [127:0] build_block(input int t, input bit pad);
        logic [127:0] blk = '0;
        for (int i = 0; i < t; i++) blk[i*8 +: 8] = cur[i];
        if (pad) blk[t*8 +: 8] = 8'h01;
        return blk;
    endfunction

    task automatic model_write(input logic [31:0] d, input logic last, input int b);
        int nb;
        int t;
        nb = last ? b : 4;
        for (int i = 0; i < nb; i++) cur.push_back(d[i*8 +: 8]);
        t = cur.size();
        if (!last) begin
            if (t == 16) begin
                exp_q.push_back({1'b0, 5'd16, build_block(16, 1'b0)});
                cur.delete();
            end
        end else begin
            if (t == 16) begin
                exp_q.push_back({1'b0, 5'd16, build_block(16, 1'b0)});
                exp_q.push_back({1'b1, 5'd0, 128'h1});
            end else begin
                exp_q.push_back({1'b1, 5'(t), build_block(t, 1'b1)});
            end
            cur.delete();
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        cur.delete();
    endtask

    task automatic do_write(input logic [31:0] d, input logic last, input int b);
        int n = 0;
        while (!wr_ready_o && n < 100) begin
            step();
            n++;
        end
        if (!wr_ready_o) begin
            total++;
            bad++;
            $display("FAIL wr_ready_timeout: got 0 expected 1");
        end else begin
            wr_en_i    = 1'b1;
            wr_data_i  = d;
            wr_last_i  = last;
            wr_bytes_i = 3'(b);
            step();
            wr_en_i   = 1'b0;
            wr_last_i = 1'b0;
            model_write(d, last, b);
        end
    endtask

    task automatic take_block();
        block_ready_i = 1'b1;
        step();
        block_ready_i = 1'b0;
    endtask

    task automatic write_full_block(input logic last_on_fourth);
        do_write(32'h03020100, 1'b0, 4);
        do_write(32'h07060504, 1'b0, 4);
        do_write(32'h0B0A0908, 1'b0, 4);
        do_write(32'h0F0E0D0C, last_on_fourth, 4);
    endtask

    // Monitor: every handshake pops one expected block.
    always @(negedge clk) begin
        if (wr_en_i && wr_last_i) begin
            assert (wr_bytes_i <= 3'd4) else $error("illegal wr_bytes_i %0d", wr_bytes_i);
        end
        if (!rst && !clear_i && block_valid_o && block_ready_i) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_block: got %h bytes=%0d last=%0b expected none",
                         block_o, block_bytes_o, block_last_o);
            end else begin
                logic [133:0] e;
                e = exp_q.pop_front();
                if ({block_last_o, block_bytes_o, block_o} !== e) begin
                    bad++;
                    $display("FAIL block: got last=%0b bytes=%0d %h expected last=%0b bytes=%0d %h",
                             block_last_o, block_bytes_o, block_o, e[133], e[132:128], e[127:0]);
                end
            end
        end
    end

    localparam logic [127:0] FULL_BLK = 128'h0F0E0D0C0B0A09080706050403020100;

    initial begin
        rst = 1'b1;
        clear_i = 1'b0;
        wr_en_i = 1'b0;
        wr_data_i = '0;
        wr_last_i = 1'b0;
        wr_bytes_i = '0;
        block_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("reset_block", block_o, '0);
        check("reset_bytes", 128'(block_bytes_o), '0);
        check("reset_valid", 128'(block_valid_o), '0);
        check("reset_last", 128'(block_last_o), '0);
        check("reset_drop", 128'(drop_pulse_o), '0);
        check("reset_wr_ready", 128'(wr_ready_o), 128'd1);

        // Four full words, no last
        write_full_block(1'b0);
        check("full_valid", 128'(block_valid_o), 128'd1);
        check("full_block", block_o, FULL_BLK);
        check("full_bytes", 128'(block_bytes_o), 128'd16);
        check("full_last", 128'(block_last_o), 128'd0);
        check("full_wr_ready", 128'(wr_ready_o), 128'd0);
        take_block();
        check("after_take_wr_ready", 128'(wr_ready_o), 128'd1);

        // Partial last word
        do_write(32'h44332211, 1'b0, 4);
        do_write(32'hDDCCBBAA, 1'b1, 1);
        check("partial_block", block_o, 128'h01AA44332211);
        check("partial_bytes", 128'(block_bytes_o), 128'd5);
        check("partial_last", 128'(block_last_o), 128'd1);
        take_block();

        // Message ends on block boundary: pad-only follow-up block
        write_full_block(1'b1);
        check("boundary_bytes", 128'(block_bytes_o), 128'd16);
        check("boundary_last", 128'(block_last_o), 128'd0);
        take_block();
        check("padblk_valid", 128'(block_valid_o), 128'd1);
        check("padblk_block", block_o, 128'h1);
        check("padblk_bytes", 128'(block_bytes_o), 128'd0);
        check("padblk_last", 128'(block_last_o), 128'd1);
        take_block();
        check("padblk_wr_ready", 128'(wr_ready_o), 128'd1);

        // Empty message
        do_write(32'hFFFFFFFF, 1'b1, 0);
        check("empty_block", block_o, 128'h1);
        check("empty_bytes", 128'(block_bytes_o), 128'd0);
        check("empty_last", 128'(block_last_o), 128'd1);
        take_block();

        // Dropped write in HOLD
        write_full_block(1'b0);
        wr_en_i = 1'b1;
        wr_data_i = 32'hDEADBEEF;
        step();
        wr_en_i = 1'b0;
        check("drop_pulse", 128'(drop_pulse_o), 128'd1);
        check("drop_block_kept", block_o, FULL_BLK);
        step();
        check("drop_pulse_end", 128'(drop_pulse_o), 128'd0);
        take_block();
        check("drop_wr_ready", 128'(wr_ready_o), 128'd1);

        // clear_i after two words, with a simultaneous write
        do_write(32'h11111111, 1'b0, 4);
        do_write(32'h22222222, 1'b0, 4);
        clear_i = 1'b1;
        wr_en_i = 1'b1;
        step();
        clear_i = 1'b0;
        wr_en_i = 1'b0;
        model_flush();
        check("clear_block", block_o, '0);
        check("clear_bytes", 128'(block_bytes_o), '0);
        check("clear_valid", 128'(block_valid_o), '0);
        check("clear_drop", 128'(drop_pulse_o), '0);
        check("clear_wr_ready", 128'(wr_ready_o), 128'd1);

        // Reset in HOLD, then a short message
        write_full_block(1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_flush();
        check("rst_hold_block", block_o, '0);
        check("rst_hold_valid", 128'(block_valid_o), '0);
        check("rst_hold_wr_ready", 128'(wr_ready_o), 128'd1);
        do_write(32'hDDCCBBAA, 1'b1, 2);
        check("post_rst_block", block_o, 128'h01BBAA);
        check("post_rst_bytes", 128'(block_bytes_o), 128'd2);
        check("post_rst_last", 128'(block_last_o), 128'd1);
        take_block();

        // Random messages with random consumer backpressure
        rand_ready = 1'b1;
        for (int m = 0; m < 150; m++) begin
            int len;
            int nwords;
            len = $urandom_range(0, 40);
            nwords = (len == 0) ? 1 : (len + 3) / 4;
            if (len > 0 && len % 4 == 0 && $urandom_range(0, 3) == 0) nwords++;
            for (int w = 0; w < nwords; w++) begin
                logic lst;
                lst = (w == nwords - 1);
                do_write($urandom, lst, lst ? len - 4 * (nwords - 1) : 4);
                if ($urandom_range(0, 3) == 0) step();
            end
        end
        rand_ready = 1'b0;
        block_ready_i = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() > 0; n++) step();
        block_ready_i = 1'b0;
        check("drain_empty", 128'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
